// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_queue
//  Purpose  : Fetch->decode decoupling queue. It is a circular buffer that
//             holds up to DEPTH {pc, instr, br_pred} entries and has
//             valid/ready handshakes on both sides. flush_i drops every
//             entry when fetch is redirected.
//  Options  : IF_ID_QUEUE_BYPASS_EN - when defined and the queue is empty,
//             an incoming entry is presented on deq_* in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module if_id_queue #(
    parameter int WIDTH  = 32,
    parameter int PRED_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       enq_valid_i,
    output logic                       enq_ready_o,
    input  logic [WIDTH-1:0]           enq_pc_i,
    input  logic [WIDTH-1:0]           enq_instr_i,
    input  logic [PRED_W-1:0]          enq_br_pred_i,
    output logic                       deq_valid_o,
    input  logic                       deq_ready_i,
    output logic [WIDTH-1:0]           deq_pc_o,
    output logic [WIDTH-1:0]           deq_instr_o,
    output logic [PRED_W-1:0]          deq_br_pred_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH+1);
    localparam int ENTRY_W = 2*WIDTH + PRED_W;

    localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(DEPTH-1);
    localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    // Entry storage; not reset, because occupancy tracking makes stale data invisible
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic             empty_w;
    logic             bypass_w;
    logic             enq_fire_w;
    logic             deq_fire_w;
    logic             wr_en_w;
    logic             rd_en_w;
    logic [ENTRY_W-1:0] head_w;

    assign head_w  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Handshake and head-of-queue outputs; enq_ready_o depends on state only
    always_comb begin
        empty_w     = (count_q == '0);
        enq_ready_o = (count_q != C_CNT_FULL);
        bypass_w    = 1'b0;
`ifdef IF_ID_QUEUE_BYPASS_EN
        bypass_w    = empty_w & enq_valid_i & ~flush_i;
`endif
        deq_valid_o = bypass_w | ~empty_w;
        if (bypass_w) begin
            deq_pc_o      = enq_pc_i;
            deq_instr_o   = enq_instr_i;
            deq_br_pred_o = enq_br_pred_i;
        end else if (!empty_w) begin
            {deq_pc_o, deq_instr_o, deq_br_pred_o} = head_w;
        end else begin
            // An all-zero instruction is the bubble that decode already understands
            deq_pc_o      = '0;
            deq_instr_o   = '0;
            deq_br_pred_o = '0;
        end
    end

    // Decide which transfers touch storage; a bypassed pass-through touches nothing
    always_comb begin
        enq_fire_w = enq_valid_i & enq_ready_o;
        deq_fire_w = deq_valid_o & deq_ready_i;
        wr_en_w    = enq_fire_w & ~flush_i & ~(bypass_w & deq_ready_i);
        rd_en_w    = deq_fire_w & ~flush_i & ~bypass_w;
    end

    // Next pointer/occupancy values; flush overrides any transfer in the same cycle
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en_w) begin
                wr_ptr_d = (wr_ptr_q == C_PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (rd_en_w) begin
                rd_ptr_d = (rd_ptr_q == C_PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en_w, rd_en_w})
                2'b10:   count_d = count_q + C_CNT_ONE;
                2'b01:   count_d = count_q - C_CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers; reset empties the queue at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Write the accepted entry into the tail slot
    always_ff @(posedge clk) begin
        if (wr_en_w) begin
            mem_q[wr_ptr_q] <= {enq_pc_i, enq_instr_i, enq_br_pred_i};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_id_queue
//  Purpose  : Directed self-checking bench for if_id_queue. It uses a DEPTH=4
//             instance for the main tests and a DEPTH=3 instance for the
//             wrap-around stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_id_queue;

    logic clk;
    logic rst_n;

    // DEPTH=4 instance signals
    logic        a_flush, a_enq_valid, a_enq_ready, a_deq_valid, a_deq_ready;
    logic [31:0] a_enq_pc, a_enq_instr, a_deq_pc, a_deq_instr;
    logic [3:0]  a_enq_pred, a_deq_pred;
    logic [2:0]  a_count;

    // DEPTH=3 instance signals
    logic        b_flush, b_enq_valid, b_enq_ready, b_deq_valid, b_deq_ready;
    logic [31:0] b_enq_pc, b_enq_instr, b_deq_pc, b_deq_instr;
    logic [3:0]  b_enq_pred, b_deq_pred;
    logic [1:0]  b_count;

    int n_assert = 0;
    int n_fail   = 0;

    if_id_queue #(.WIDTH(32), .PRED_W(4), .DEPTH(4)) u_dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (a_flush),
        .enq_valid_i   (a_enq_valid),
        .enq_ready_o   (a_enq_ready),
        .enq_pc_i      (a_enq_pc),
        .enq_instr_i   (a_enq_instr),
        .enq_br_pred_i (a_enq_pred),
        .deq_valid_o   (a_deq_valid),
        .deq_ready_i   (a_deq_ready),
        .deq_pc_o      (a_deq_pc),
        .deq_instr_o   (a_deq_instr),
        .deq_br_pred_o (a_deq_pred),
        .count_o       (a_count)
    );

    if_id_queue #(.WIDTH(32), .PRED_W(4), .DEPTH(3)) u_dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (b_flush),
        .enq_valid_i   (b_enq_valid),
        .enq_ready_o   (b_enq_ready),
        .enq_pc_i      (b_enq_pc),
        .enq_instr_i   (b_enq_instr),
        .enq_br_pred_i (b_enq_pred),
        .deq_valid_o   (b_deq_valid),
        .deq_ready_i   (b_deq_ready),
        .deq_pc_o      (b_deq_pc),
        .deq_instr_o   (b_deq_instr),
        .deq_br_pred_o (b_deq_pred),
        .count_o       (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one entry on the DEPTH=4 queue for a single cycle with decode stalled
    task automatic push_a(input logic [31:0] pc);
        a_enq_valid = 1'b1;
        a_enq_pc    = pc;
        a_enq_instr = 32'hA000_0000 | pc;
        a_enq_pred  = pc[5:2];
        a_deq_ready = 1'b0;
        cyc();
        a_enq_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_list [2];
        logic [31:0] sb [$];
        logic [31:0] exp_pc;
        int          sent;
        int          rcvd;

        rst_n = 1'b0;
        a_flush = 1'b0; a_enq_valid = 1'b0; a_deq_ready = 1'b0;
        a_enq_pc = '0; a_enq_instr = '0; a_enq_pred = '0;
        b_flush = 1'b0; b_enq_valid = 1'b0; b_deq_ready = 1'b0;
        b_enq_pc = '0; b_enq_instr = '0; b_enq_pred = '0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_count",     32'(a_count),     32'd0);
        check_eq("rst_enq_ready", 32'(a_enq_ready), 32'd1);
        check_eq("rst_deq_valid", 32'(a_deq_valid), 32'd0);
        check_eq("rst_deq_instr", a_deq_instr,      32'd0);
        check_eq("rst_deq_pc",    a_deq_pc,         32'd0);
        rst_n = 1'b1;
        cyc();

        // ---------------- fill to full ----------------
        for (int i = 0; i < 4; i++) push_a(32'h100 + 32'(4*i));
        #1;
        check_eq("fill_count",     32'(a_count),     32'd4);
        check_eq("fill_enq_ready", 32'(a_enq_ready), 32'd0);
        check_eq("fill_head_pc",   a_deq_pc,         32'h100);
        check_eq("fill_head_ins",  a_deq_instr,      32'hA000_0100);
        check_eq("fill_head_pred", 32'(a_deq_pred),  32'h0);

        // 5th enqueue refused while full
        a_enq_valid = 1'b1; a_enq_pc = 32'h110; a_enq_instr = 32'hA000_0110;
        cyc();
        check_eq("full_refuse_count", 32'(a_count), 32'd4);

        // full: enq+deq together -> only the deq happens
        a_deq_ready = 1'b1;
        cyc();
        a_enq_valid = 1'b0; a_deq_ready = 1'b0;
        #1;
        check_eq("full_simul_count", 32'(a_count), 32'd3);
        check_eq("full_simul_head",  a_deq_pc,     32'h104);

        // single deq
        a_deq_ready = 1'b1;
        cyc();
        a_deq_ready = 1'b0;
        #1;
        check_eq("deq_count", 32'(a_count), 32'd2);
        check_eq("deq_head",  a_deq_pc,     32'h108);

        // count=2: enq 0x200 + deq together
        a_enq_valid = 1'b1; a_enq_pc = 32'h200; a_enq_instr = 32'hA000_0200; a_enq_pred = 4'h5;
        a_deq_ready = 1'b1;
        cyc();
        a_enq_valid = 1'b0; a_deq_ready = 1'b0;
        #1;
        check_eq("simul_count", 32'(a_count), 32'd2);
        check_eq("simul_head",  a_deq_pc,     32'h10C);

        // drain remaining entries in order
        exp_list[0] = 32'h10C;
        exp_list[1] = 32'h200;
        a_deq_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_eq("drain_valid", 32'(a_deq_valid), 32'd1);
            check_eq("drain_pc",    a_deq_pc,         exp_list[i]);
            cyc();
        end
        #1;
        check_eq("drain_empty_valid", 32'(a_deq_valid), 32'd0);
        check_eq("drain_empty_count", 32'(a_count),     32'd0);
        check_eq("drain_empty_instr", a_deq_instr,      32'd0);
        a_deq_ready = 1'b0;
        cyc();

        // ---------------- flush ----------------
        for (int i = 0; i < 3; i++) push_a(32'h310 + 32'(4*i));
        check_eq("pre_flush_count", 32'(a_count), 32'd3);
        a_flush = 1'b1;
        a_enq_valid = 1'b1; a_enq_pc = 32'h300; a_enq_instr = 32'hA000_0300;
        cyc();
        a_flush = 1'b0; a_enq_valid = 1'b0;
        #1;
        check_eq("flush_count",     32'(a_count),     32'd0);
        check_eq("flush_deq_valid", 32'(a_deq_valid), 32'd0);
        check_eq("flush_enq_ready", 32'(a_enq_ready), 32'd1);
        a_deq_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            check_eq("flush_no_300", a_deq_pc, 32'd0);
        end
        a_deq_ready = 1'b0;
        push_a(32'h320);
        #1;
        check_eq("post_flush_count", 32'(a_count), 32'd1);
        check_eq("post_flush_head",  a_deq_pc,     32'h320);
        a_deq_ready = 1'b1;
        cyc();
        a_deq_ready = 1'b0;
        check_eq("post_flush_drain", 32'(a_count), 32'd0);

        // ---------------- async reset mid-traffic ----------------
        for (int i = 0; i < 3; i++) push_a(32'h500 + 32'(4*i));
        check_eq("pre_rst_count", 32'(a_count), 32'd3);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_count",     32'(a_count),     32'd0);
        check_eq("async_rst_deq_valid", 32'(a_deq_valid), 32'd0);
        check_eq("async_rst_deq_instr", a_deq_instr,      32'd0);
        check_eq("async_rst_enq_ready", 32'(a_enq_ready), 32'd1);
        cyc();
        rst_n = 1'b1;
        cyc();

        // ---------------- empty-queue enq with decode ready ----------------
        a_enq_valid = 1'b1; a_enq_pc = 32'h400; a_enq_instr = 32'hA000_0400; a_enq_pred = 4'h9;
        a_deq_ready = 1'b1;
        #1;
`ifdef IF_ID_QUEUE_BYPASS_EN
        check_eq("byp_valid", 32'(a_deq_valid), 32'd1);
        check_eq("byp_pc",    a_deq_pc,         32'h400);
        check_eq("byp_instr", a_deq_instr,      32'hA000_0400);
        check_eq("byp_pred",  32'(a_deq_pred),  32'h9);
        cyc();
        a_enq_valid = 1'b0;
        #1;
        check_eq("byp_count_after", 32'(a_count),     32'd0);
        check_eq("byp_valid_after", 32'(a_deq_valid), 32'd0);
`else
        check_eq("nobyp_valid_same", 32'(a_deq_valid), 32'd0);
        check_eq("nobyp_pc_same",    a_deq_pc,         32'd0);
        cyc();
        a_enq_valid = 1'b0;
        #1;
        check_eq("nobyp_valid_next", 32'(a_deq_valid), 32'd1);
        check_eq("nobyp_pc_next",    a_deq_pc,         32'h400);
        check_eq("nobyp_pred_next",  32'(a_deq_pred),  32'h9);
        check_eq("nobyp_count_next", 32'(a_count),     32'd1);
        cyc();
        check_eq("nobyp_count_drain", 32'(a_count), 32'd0);
`endif
        a_deq_ready = 1'b0;

        // ---------------- wrap-around stream on DEPTH=3 ----------------
        sent = 0;
        rcvd = 0;
        for (int c = 0; c < 300 && rcvd < 10; c++) begin
            b_enq_valid = (sent < 10);
            b_enq_pc    = 32'h600 + 32'(4*sent);
            b_enq_instr = 32'hB000_0000 | 32'(sent);
            b_enq_pred  = 4'(sent);
            b_deq_ready = 1'($urandom_range(0, 1));
            #1;
            if (b_enq_valid && b_enq_ready) begin
                sb.push_back(b_enq_pc);
                sent++;
            end
            if (b_deq_valid && b_deq_ready) begin
                if (sb.size() == 0) begin
                    check_eq("wrap_underflow", 32'd1, 32'd0);
                end else begin
                    exp_pc = sb.pop_front();
                    check_eq("wrap_order", b_deq_pc, exp_pc);
                end
                rcvd++;
            end
            cyc();
            check_eq("wrap_count",     32'(b_count),          32'(sb.size()));
            check_eq("wrap_count_max", 32'(b_count <= 2'd3),  32'd1);
        end
        b_enq_valid = 1'b0;
        b_deq_ready = 1'b0;
        check_eq("wrap_all_rcvd", 32'(rcvd), 32'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
